// File: rtl/simmem_reqack_rv_adapter.sv
// REQ/ACK destination-side consumer: acks one word per handshake after AckDelay cycles,
// buffers it in a small FIFO and streams it out as valid/ready. Optional checks: SIMMEM_REQACK_ADAPTER_ASSERT_EN.
module simmem_reqack_rv_adapter #(
    parameter int DataWidth = 32,
    parameter int Depth     = 4,
    parameter int AckDelay  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    input  logic [DataWidth-1:0]       data_i,
    output logic                       ack_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [DataWidth-1:0]       out_data_o,
    output logic [$clog2(Depth+1)-1:0] occupancy_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int OccW = $clog2(Depth+1);
    localparam int CntW = (AckDelay > 0) ? $clog2(AckDelay+1) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    logic [1:0]           r_state;
    logic [CntW-1:0]      r_cnt;
    logic [DataWidth-1:0] r_mem [Depth];
    logic [PtrW-1:0]      r_wr_ptr;
    logic [PtrW-1:0]      r_rd_ptr;
    logic [OccW-1:0]      r_occ;
    logic [DataWidth-1:0] r_last;

    logic w_pop;
    logic w_space;
    logic w_cnt_done;
    logic w_push;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_pop      = (r_occ != '0) && out_ready_i;
    assign w_space    = (r_occ != OccW'(Depth)) || w_pop;
    assign w_cnt_done = (r_cnt == CntW'(AckDelay));
    assign w_push     = (r_state == ST_DELAY) && req_i && w_cnt_done && w_space;

    assign ack_o       = w_push;
    assign out_valid_o = (r_occ != '0);
    assign out_data_o  = (r_occ != '0) ? r_mem[r_rd_ptr] : r_last;
    assign occupancy_o = r_occ;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (req_i) r_state <= ST_DELAY;
                end
                ST_DELAY: begin
                    if (!req_i) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_push) begin
                        r_state <= ST_GUARD;
                        r_cnt   <= '0;
                    end else if (!w_cnt_done) begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                ST_GUARD: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_last   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
                r_last   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OccW'(1);
                2'b01:   r_occ <= r_occ - OccW'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef SIMMEM_REQACK_ADAPTER_ASSERT_EN
    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == ST_DELAY) |-> req_i);
    a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_state == ST_DELAY && req_i && $past(req_i)) |-> $stable(data_i));
    a_single_ack: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ack_o |=> !ack_o);
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_push && r_occ == OccW'(Depth)) |-> w_pop);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (out_valid_o && out_ready_i) |-> (r_occ != '0));
`endif

endmodule

// File: tb/tb_simmem_reqack_rv_adapter.sv
// Scoreboard bench: words are queued at issue, a negedge monitor checks order, occupancy and ack legality.
module tb_simmem_reqack_rv_adapter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int DLY   = 2;

    logic          clk = 0;
    logic          rst_n = 0;
    logic          req = 0;
    logic [DW-1:0] data = '0;
    logic          ready = 0;
    logic          ack, vld;
    logic [DW-1:0] odata;
    logic [2:0]    occ;

    logic          req0 = 0;
    logic          ready0 = 1;
    logic [DW-1:0] data0 = 32'h0C0F_FEE0;
    logic          ack0, vld0;
    logic [DW-1:0] odata0;
    logic [2:0]    occ0;

    int n_chk = 0;
    int n_err = 0;
    int n_ack = 0;
    int n_sent = 0;
    int m_occ = 0;
    logic [DW-1:0] q_exp[$];
    logic [DW-1:0] last_pop = '0;
    logic [DW-1:0] exp_w;
    logic          prev_ack = 0;
    logic          mon_pop;
    bit            rnd_done;

    always #5 clk = ~clk;

    simmem_reqack_rv_adapter #(.DataWidth(DW), .Depth(DEPTH), .AckDelay(DLY)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .data_i(data), .ack_o(ack),
        .out_valid_o(vld), .out_ready_i(ready), .out_data_o(odata), .occupancy_o(occ));

    simmem_reqack_rv_adapter #(.DataWidth(DW), .Depth(DEPTH), .AckDelay(0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req0), .data_i(data0), .ack_o(ack0),
        .out_valid_o(vld0), .out_ready_i(ready0), .out_data_o(odata0), .occupancy_o(occ0));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: model occupancy = acks - pops, words leave in issue order.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_occ    = 0;
            q_exp.delete();
            last_pop = '0;
            prev_ack = 0;
        end else begin
            chk("occupancy", occ, m_occ);
            chk("out_valid", vld, m_occ != 0);
            if (m_occ == 0) chk("hold_data", odata, last_pop);
            mon_pop = vld && ready;
            if (mon_pop) begin
                if (q_exp.size() == 0) chk("pop_without_word", 1, 0);
                else begin
                    exp_w = q_exp.pop_front();
                    chk("data_order", odata, exp_w);
                    last_pop = exp_w;
                end
            end
            if (ack) begin
                n_ack++;
                chk("ack_space", (m_occ < DEPTH) || mon_pop, 1);
                chk("double_ack", prev_ack, 0);
            end
            prev_ack = ack;
            m_occ = m_occ + int'(ack) - int'(mon_pop);
        end
    end

    // exp_cyc < 0: latency not checked (random backpressure may stall the ack).
    task automatic send(input logic [DW-1:0] d, input int exp_cyc);
        int  n = 0;
        bit  got = 0;
        q_exp.push_back(d);
        n_sent++;
        req = 1; data = d;
        while (!got && n < 200) begin
            @(negedge clk);
            if (ack) got = 1; else n++;
        end
        if (!got) chk("ack_timeout", 0, 1);
        else if (exp_cyc >= 0) chk("ack_latency", n, exp_cyc);
        @(posedge clk); #1;
        req = 0; data = $urandom;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        ready = 1;
        while (m_occ != 0 && n < 100) begin @(negedge clk); n++; end
        if (m_occ != 0) chk("drain_timeout", m_occ, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] w1, w2, w3;

        #2;
        chk("rst_ack", ack, 0);
        chk("rst_valid", vld, 0);
        chk("rst_data", odata, 0);
        chk("rst_occ", occ, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        // Single transfer: ack in cycle AckDelay+1 after req rise.
        ready = 1;
        send(32'hA5A5_0001, DLY + 1);
        @(posedge clk); #1;

        // Back-to-back, unobstructed.
        for (int i = 0; i < 8; i++) send($urandom, DLY + 1);
        drain();

        // Random backpressure.
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 12; i++) send($urandom, -1);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();

        // Backpressure: fill, then a fifth request stalls until a pop frees a slot.
        ready = 0;
        for (int i = 0; i < DEPTH; i++) send($urandom, DLY + 1);
        chk("bp_full_occ", occ, DEPTH);
        w1 = $urandom;
        q_exp.push_back(w1);
        n_sent++;
        req = 1; data = w1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_no_ack", ack, 0);
        end
        @(posedge clk); #1 ready = 1;
        @(negedge clk);
        chk("bp_ack_on_pop", ack, 1);
        @(posedge clk); #1;
        ready = 0; req = 0;
        @(negedge clk);
        chk("bp_occ_kept", occ, DEPTH);
        @(posedge clk); #1;
        drain();

        // Simultaneous push/pop at occupancy 2.
        ready = 0;
        w1 = $urandom; w2 = $urandom; w3 = $urandom;
        send(w1, DLY + 1);
        send(w2, DLY + 1);
        q_exp.push_back(w3);
        n_sent++;
        req = 1; data = w3;
        repeat (DLY + 1) @(posedge clk);
        #1 ready = 1;
        @(negedge clk);
        chk("pp_ack", ack, 1);
        @(posedge clk); #1;
        ready = 0; req = 0;
        @(negedge clk);
        chk("pp_occ", occ, 2);
        chk("pp_head", odata, w2);
        @(posedge clk); #1;
        drain();

        // Reset mid-DELAY with 3 words buffered.
        ready = 0;
        for (int i = 0; i < 3; i++) send($urandom, DLY + 1);
        req = 1; data = $urandom;
        repeat (2) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_ack", ack, 0);
        chk("rst_mid_valid", vld, 0);
        chk("rst_mid_occ", occ, 0);
        @(posedge clk); #1;
        rst_n = 1; req = 0;
        @(posedge clk); #1;
        ready = 1;
        send(32'h5EED_0002, DLY + 1);
        drain();

        // AckDelay=0 with req held: ack every third cycle.
        @(posedge clk); #1 req0 = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("d0_ack_pattern", ack0, (k >= 1) && ((k - 1) % 3 == 0));
            if (vld0) chk("d0_data", odata0, 32'h0C0F_FEE0);
        end
        @(posedge clk); #1 req0 = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("ack_count", n_ack, n_sent);
        chk("final_occ", occ, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/simmem_reqack_rv_adapter.md
Name: simmem_reqack_rv_adapter

Overview:
- Destination-side consumer of a REQ/ACK synchronizer. Sits directly downstream of the synchronizer's dst_req/dst_ack pair.
- Accepts one data word per REQ/ACK handshake after a programmable acknowledge delay.
- Buffers accepted words in a small FIFO and presents them as a valid/ready stream to the linked-list bank front-end.
- Guarantees exactly one ACK per request and never acknowledges while the FIFO is full.

Parameters:
- DataWidth, 32, width of transferred word.
- Depth, 4, FIFO entries; power of two, >= 2.
- AckDelay, 2, minimum cycles req_i must be seen high before ack_o; 0 = acknowledge in the first cycle req_i is seen.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- req_i  in  1  request level from synchronizer dst_req.
- data_i  in  DataWidth  word, stable while req_i high.
- ack_o  out  1  single-cycle acknowledge to synchronizer dst_ack.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  DataWidth  FIFO head data.
- occupancy_o  out  $clog2(Depth+1)  current FIFO fill level.

Interface note: one clock; reset is asynchronous and active-low (clk_i, rst_ni).

Behaviour:
- Reset values: ack_o=0, out_valid_o=0, out_data_o=0, occupancy_o=0. FSM=IDLE, delay counter=0, FIFO pointers=0.
- FSM states:
  - IDLE: if req_i, go to DELAY with counter=0.
  - DELAY: counter increments each cycle while counter<AckDelay. When counter==AckDelay and FIFO has space, ack_o=1 combinationally in that cycle, data_i is pushed, and the FSM goes to GUARD.
  - GUARD: exactly one cycle; req_i is ignored; then go to IDLE.
- "Has space" means occupancy<Depth, or occupancy==Depth with a pop in the same cycle (out_valid_o && out_ready_i). Simultaneous push and pop leaves occupancy unchanged.
- AckDelay=0: ack_o may assert in the first DELAY cycle. Minimum latency from req_i rise to ack_o is AckDelay+1 cycles, since IDLE registers the request.
- FIFO full at ack time: stay in DELAY with the counter saturated at AckDelay and ack_o=0 until space frees. The ack then fires in the same cycle as the freeing pop.
- req_i dropping in DELAY without an ack is a protocol violation. The FSM returns to IDLE, no push, counter cleared.
- Output path:
  - out_valid_o = (occupancy!=0).
  - out_data_o is the head entry, and holds its value while out_valid_o && !out_ready_i.
  - Pop occurs on out_valid_o && out_ready_i.
  - When empty, out_data_o holds the last popped value (0 after reset).
- Pointers: log2(Depth) bits, wrap naturally. occupancy is tracked with a separate counter of width $clog2(Depth+1).
- Words leave strictly in ack order. Fall-through latency from ack to out_valid_o is 1 cycle, since the FIFO is registered.
- Reset asserted mid-operation: everything returns to reset values immediately (asynchronous). Buffered words are discarded; no ack is issued.

Optional Feature:
- SIMMEM_REQACK_ADAPTER_ASSERT_EN.
- Defined: concurrent assertions (clk_i, disabled during !rst_ni) flag:
  - req_i falling in DELAY;
  - data_i changing while req_i high in DELAY;
  - ack_o high two consecutive cycles;
  - push when occupancy==Depth without a pop;
  - pop when empty.
- Not defined: no assertion code is compiled; functional behaviour is identical.

Test Plan:
- Single transfer, AckDelay=2, out_ready_i=1: req_i rises at cycle 0 with data_i=0xA5A5_0001 -> ack_o high only in cycle 3; out_valid_o high in cycle 4 with out_data_o=0xA5A5_0001; occupancy_o returns to 0 in cycle 5.
- Back-to-back: 8 handshakes, each request re-raised 1 cycle after GUARD, out_ready_i=1 -> exactly 8 ack_o pulses, outputs 8 words in order, final occupancy_o=0.
- Backpressure: out_ready_i=0, 5 requests with Depth=4 -> 4 acks, occupancy_o=4, 5th req_i held with ack_o=0. Raising out_ready_i for one cycle -> ack_o pulses in that same cycle; occupancy_o stays 4.
- Simultaneous push/pop at occupancy 2 -> occupancy_o stays 2; head advances one entry.
- Reset mid-DELAY with 3 words buffered: rst_ni low for 1 cycle -> ack_o=0, out_valid_o=0, occupancy_o=0 immediately. Subsequent request completes normally.
- AckDelay=0, req_i held high continuously -> ack_o pulses every 3rd cycle (DELAY, GUARD, IDLE), with no double ack.
